// File: rtl/row_packer.sv
// -----------------------------------------------------------------------------
// row_packer
//
// Collects an upstream byte stream into 20-byte rows and writes each completed
// (or flushed, zero-padded) row to a frame buffer in a single-cycle burst. Row
// start addresses advance by 20 from BASE_ADDR and wrap after ROWS rows, at
// which point frame_done pulses alongside the final write.
//
// Parameters
//   BASE_ADDR  first byte address of the frame buffer
//   ROWS       rows per frame; ROWS*20 + BASE_ADDR must not exceed 1000
//
// Ports
//   clk         in   1    clock, rising edge
//   reset       in   1    synchronous, active-high reset
//   in_valid    in   1    upstream byte valid
//   in_data     in   8    upstream pixel byte
//   in_ready    out  1    packer accepts a byte this cycle
//   flush       in   1    write the current partial row, zero-padded
//   mem_en      out  1    memory enable, high only in the write cycle
//   mem_r_w     out  1    constant 0 (write)
//   mem_insign  out  1    constant 0 (20-byte burst mode)
//   mem_abus    out  16   row start address, held between writes
//   mem_dbus    out  160  packed row, byte k on [8k+7:8k], held between writes
//   row_cnt     out  8    rows written in the current frame
//   frame_done  out  1    pulses with the write of the last row of a frame
// -----------------------------------------------------------------------------
module row_packer #(
   parameter logic [15:0] BASE_ADDR = 16'd0,
   parameter int          ROWS      = 40
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   input  logic [7:0]   in_data,
   output logic         in_ready,
   input  logic         flush,
   output logic         mem_en,
   output logic         mem_r_w,
   output logic         mem_insign,
   output logic [15:0]  mem_abus,
   output logic [159:0] mem_dbus,
   output logic [7:0]   row_cnt,
   output logic         frame_done
);

   typedef enum logic {
      FILL  = 1'b0,
      WRITE = 1'b1
   } state_t;

   localparam logic [4:0]  LAST_LANE = 5'd19;
   localparam logic [7:0]  LAST_ROW  = 8'(ROWS - 1);
   localparam logic [15:0] ROW_BYTES = 16'd20;

   state_t         state;
   state_t         state_next;
   logic [4:0]     byte_idx;
   logic [159:0]   row_q;
   logic [159:0]   dbus_hold;
   logic [15:0]    wr_addr;
   logic [15:0]    abus_hold;
   logic [7:0]     row_cnt_q;
   logic           accept;
   logic           in_write;
   logic           last_row;

   assign last_row = (row_cnt_q == LAST_ROW);

   // State register.
   // NOTE: every clocked assignment uses <= so all registers update together
   // from values sampled before the edge; = here would create order-dependent
   // races between always_ff blocks.
   always_ff @(posedge clk) begin
      if (reset) state <= FILL;
      else       state <= state_next;
   end

   // Next-state and control outputs.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can
      // leave one unassigned and infer a latch.
      state_next = state;
      in_write   = 1'b0;
      in_ready   = 1'b0;
      accept     = 1'b0;

      unique case (state)
         FILL: begin
            in_ready = !reset;
            accept   = in_valid && !reset;
            // A flush on an empty row only counts if it carries a byte in.
            if ((accept && byte_idx == LAST_LANE) ||
                (flush && (accept || byte_idx != 5'd0)))
               state_next = WRITE;
         end
         WRITE: begin
            in_write   = 1'b1;
            state_next = FILL;
         end
         default: state_next = FILL;
      endcase
   end

   // Reset suppresses a write that would otherwise be in progress.
   assign mem_en     = in_write && !reset;
   assign frame_done = mem_en && last_row;
   assign mem_r_w    = 1'b0;
   assign mem_insign = 1'b0;

   // Memory buses show the live row only while enabled, otherwise the
   // values presented by the previous write.
   assign mem_abus = mem_en ? wr_addr : abus_hold;
   assign mem_dbus = mem_en ? row_q   : dbus_hold;
   assign row_cnt  = row_cnt_q;

   // Row assembly and address bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: the 160-bit row register is reset deliberately: the padding
         // lanes of a flushed row must read as zero and mem_dbus has a defined
         // reset value, so it is ordinary state rather than a storage array.
         byte_idx  <= 5'd0;
         row_q     <= '0;
         dbus_hold <= '0;
         wr_addr   <= BASE_ADDR;
         abus_hold <= BASE_ADDR;
         row_cnt_q <= 8'd0;
      end else begin
         unique case (state)
            FILL: begin
               if (accept)
                  row_q[byte_idx*8 +: 8] <= in_data;
               if (state_next == WRITE)
                  byte_idx <= 5'd0;
               else if (accept)
                  byte_idx <= byte_idx + 5'd1;
            end
            WRITE: begin
               abus_hold <= wr_addr;
               dbus_hold <= row_q;
               // Clearing here means a later flush pads with zeros for free.
               row_q     <= '0;
               if (last_row) begin
                  wr_addr   <= BASE_ADDR;
                  row_cnt_q <= 8'd0;
               end else begin
                  wr_addr   <= wr_addr + ROW_BYTES;
                  row_cnt_q <= row_cnt_q + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/row_packer.md
ROW_PACKER -- requirements
Module: row_packer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'd0, first memory byte address of the frame buffer.
REQ-002 SHALL have parameter ROWS, default 40, number of 20-byte rows per frame; ROWS*20+BASE_ADDR SHALL NOT exceed 1000.
REQ-003 SHALL have port clk  input  1  clock, all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  upstream byte valid.
REQ-006 SHALL have port in_data  input  8  upstream pixel byte.
REQ-007 SHALL have port in_ready  output  1  packer can accept a byte this cycle.
REQ-008 SHALL have port flush  input  1  single-cycle request to write the current partial row, zero-padded.
REQ-009 SHALL have port mem_en  output  1  memory enable, drives the row memory en.
REQ-010 SHALL have port mem_r_w  output  1  always 0 (write).
REQ-011 SHALL have port mem_insign  output  1  always 0 (20-byte burst mode).
REQ-012 SHALL have port mem_abus  output  16  row start address.
REQ-013 SHALL have port mem_dbus  output  160  packed row; byte k (0..19) on bits [8k+7:8k] maps to memory dbus_in(k+1).
REQ-014 SHALL have port row_cnt  output  8  rows written in the current frame.
REQ-015 SHALL have port frame_done  output  1  one-cycle pulse when the last row of a frame is written.

Function
REQ-016 SHALL implement FSM states FILL and WRITE; reset state FILL.
REQ-017 In FILL: in_ready=1; a byte is accepted when in_valid&in_ready and stored at lane byte_idx; byte_idx increments 0..19.
REQ-018 Accepting the byte with byte_idx=19 SHALL transition to WRITE next cycle; byte_idx returns to 0.
REQ-019 In WRITE (exactly one cycle): mem_en=1, mem_abus=wr_addr, mem_dbus=row register, in_ready=0; next state FILL.
REQ-020 mem_en SHALL be 0 in every cycle outside WRITE; mem_dbus and mem_abus SHALL hold their last values when mem_en=0.
REQ-021 Latency: mem_en asserts the cycle after the 20th byte is accepted.
REQ-022 After each WRITE, wr_addr SHALL increase by 20 and row_cnt by 1.
REQ-023 On the WRITE of row ROWS-1: frame_done=1 that cycle, then wr_addr wraps to BASE_ADDR and row_cnt to 0.
REQ-024 flush in FILL with byte_idx>0 SHALL force WRITE next cycle; unfilled lanes SHALL be 8'h00.
REQ-025 flush with byte_idx=0 and no byte accepted that cycle SHALL be ignored.
REQ-026 flush coincident with an accepted byte: byte stored first, then the row written (including that byte).
REQ-027 flush asserted in WRITE SHALL be ignored.
REQ-028 Row register lanes SHALL be cleared to 8'h00 on entry to FILL after each WRITE.
REQ-029 Address arithmetic SHALL be 16-bit unsigned; no overflow within the legal parameter range.

Reset
REQ-030 reset SHALL override all activity, including a WRITE in progress; the next cycle has mem_en=0.
REQ-031 Reset values: state FILL, byte_idx 0, in_ready 1 (from the first cycle after reset), mem_en 0, mem_r_w 0, mem_insign 0, mem_abus BASE_ADDR, mem_dbus 0, row_cnt 0, frame_done 0, wr_addr BASE_ADDR.
REQ-032 in_ready SHALL be 0 while reset is high.

Verification
REQ-033 Stream bytes 0x01..0x14 back-to-back -> one cycle later mem_en=1, mem_abus=0x0000, lane0=0x01, lane19=0x14, in_ready=0 that cycle.
REQ-034 Stream 40 full rows (ROWS=40) -> mem_abus sequence 0,20,...,780; frame_done pulses with the write at 780; the next row writes at 0 and row_cnt=1 after it.
REQ-035 Send 5 bytes 0xAA then flush -> write at current wr_addr, lanes 0-4=0xAA, lanes 5-19=0x00; the next row starts at lane 0.
REQ-036 Flush with empty row; flush in the same cycle as the 3rd byte 0x55 -> no write for the first; the second writes lanes 0-2 including 0x55.
REQ-037 Assert reset in the WRITE cycle after 20 bytes -> mem_en=0 next cycle, row_cnt=0, the next row written at BASE_ADDR.
REQ-038 Toggle in_valid randomly over 3 rows -> only accepted bytes are stored, in order, with no loss or duplication.
